// File: rtl/snax_tcdm_req_buffer.sv
// HWPE-to-SNAX TCDM request adapter: a 2-entry request FIFO plus a pending-read credit
// counter, so the number of unanswered reads stays bounded.
module snax_tcdm_req_buffer #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 hwpe_req_i,
   output logic                                 hwpe_gnt_o,
   input  logic [AddrWidth-1:0]                 hwpe_add_i,
   input  logic                                 hwpe_wen_i,
   input  logic [DataWidth/8-1:0]               hwpe_be_i,
   input  logic [DataWidth-1:0]                 hwpe_data_i,
   output logic [DataWidth-1:0]                 hwpe_r_data_o,
   output logic                                 hwpe_r_valid_o,
   output logic                                 tcdm_q_valid_o,
   input  logic                                 tcdm_q_ready_i,
   output logic [AddrWidth-1:0]                 tcdm_q_addr_o,
   output logic                                 tcdm_q_write_o,
   output logic [DataWidth/8-1:0]               tcdm_q_strb_o,
   output logic [DataWidth-1:0]                 tcdm_q_data_o,
   input  logic                                 tcdm_p_valid_i,
   input  logic [DataWidth-1:0]                 tcdm_p_data_i,
   output logic [$clog2(MaxOutstanding+1)-1:0]  pending_o,
   output logic                                 err_unexpected_rsp_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

   logic [AddrWidth-1:0] addr_q  [2];
   logic                 write_q [2];
   logic [StrbWidth-1:0] strb_q  [2];
   logic [DataWidth-1:0] data_q  [2];

   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic [CntWidth-1:0]  pending;
   logic                 active;
   logic                 err;
   logic                 r_valid;
   logic [DataWidth-1:0] r_data;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic read_ok;
   logic read_push;
   logic rsp_ok;

   // active keeps the grant low while reset is held, without a combinational path from rst_ni
   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   assign read_ok   = !hwpe_wen_i || (pending < MaxCnt);
   assign hwpe_gnt_o = hwpe_req_i && active && !full && read_ok;
   assign push      = hwpe_req_i && hwpe_gnt_o;
   assign pop       = tcdm_q_valid_o && tcdm_q_ready_i;
   assign read_push = push && hwpe_wen_i;
   assign rsp_ok    = tcdm_p_valid_i && (pending != '0);

   assign tcdm_q_valid_o = !empty;
   assign tcdm_q_addr_o  = addr_q[rd_ptr];
   assign tcdm_q_write_o = write_q[rd_ptr];
   assign tcdm_q_strb_o  = strb_q[rd_ptr];
   assign tcdm_q_data_o  = data_q[rd_ptr];

   assign pending_o            = pending;
   assign hwpe_r_valid_o       = r_valid;
   assign hwpe_r_data_o        = r_data;
   assign err_unexpected_rsp_o = err;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (push && !pop)      count <= count + 2'd1;
         else if (!push && pop) count <= count - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[wr_ptr]  <= hwpe_add_i;
         write_q[wr_ptr] <= ~hwpe_wen_i;
         strb_q[wr_ptr]  <= hwpe_be_i;
         data_q[wr_ptr]  <= hwpe_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending <= '0;
      end else if (read_push && !rsp_ok) begin
         pending <= pending + CntWidth'(1);
      end else if (!read_push && rsp_ok) begin
         pending <= pending - CntWidth'(1);
      end
   end

   // A response with no pending read is dropped and flagged until the next reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         active  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         err     <= 1'b0;
      end else begin
         active  <= 1'b1;
         r_valid <= rsp_ok;
         if (tcdm_p_valid_i) r_data <= tcdm_p_data_i;
         if (tcdm_p_valid_i && (pending == '0)) err <= 1'b1;
      end
   end

endmodule
